// File: rtl/order_rate_limiter.sv
// ----------------------------------------------------------------------------
// risk_pkg
//   Shared enumerations for the order risk pipeline. The rate limiter and the
//   position limiter both speak these types on their order ports.
// ----------------------------------------------------------------------------
package risk_pkg;

   typedef enum logic {
      SIDE_BUY  = 1'b0,
      SIDE_SELL = 1'b1
   } order_side_e;

   typedef enum logic [1:0] {
      ORDER_NEW    = 2'd0,
      ORDER_MODIFY = 2'd1,
      ORDER_CANCEL = 2'd2
   } order_type_e;

   typedef enum logic [2:0] {
      RISK_OK             = 3'd0,
      RISK_RATE_LIMIT     = 3'd1,
      RISK_POSITION_LIMIT = 3'd2,
      RISK_NOTIONAL_LIMIT = 3'd3
   } risk_reject_e;

endpackage : risk_pkg

// ----------------------------------------------------------------------------
// order_rate_limiter
//   Token-bucket order-rate check sitting directly upstream of the position
//   limiter. Each new/modify order costs one token; cancels are free. Orders
//   that pass go through a 1-deep registered valid/ready stage, orders that
//   find the bucket empty are dropped and reported as a one-cycle pulse on
//   rej_valid/rej_reason.
//
//   The bucket is refilled by cfg_refill_tokens once every cfg_refill_period
//   cycles (a period of 0 behaves as 1) and never exceeds cfg_max_tokens.
//   With cfg_enabled low every order passes and no token is spent.
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   cfg_max_tokens                bucket capacity
//   cfg_refill_tokens             tokens added per refill tick
//   cfg_refill_period             cycles per refill tick (0 treated as 1)
//   cfg_enabled                   0 = bypass (all pass, no token use)
//   in_valid / in_ready           upstream handshake
//   in_side/type/qty/notional     upstream order payload
//   out_valid / out_ready         downstream handshake (position limiter)
//   out_side/type/qty/notional    registered order payload
//   rej_valid / rej_reason        one-cycle reject pulse and its reason
//   tokens_available              current bucket level
//   total_passed/total_rejected   64-bit wrapping order counters
// ----------------------------------------------------------------------------
module order_rate_limiter
   import risk_pkg::*;
#(
   parameter int QTY_WIDTH      = 64,
   parameter int NOTIONAL_WIDTH = 64,
   parameter int TOKEN_WIDTH    = 16,
   parameter int PERIOD_WIDTH   = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,

   input  logic [TOKEN_WIDTH-1:0]    cfg_max_tokens,
   input  logic [TOKEN_WIDTH-1:0]    cfg_refill_tokens,
   input  logic [PERIOD_WIDTH-1:0]   cfg_refill_period,
   input  logic                      cfg_enabled,

   input  logic                      in_valid,
   output logic                      in_ready,
   input  order_side_e               in_side,
   input  order_type_e               in_type,
   input  logic [QTY_WIDTH-1:0]      in_qty,
   input  logic [NOTIONAL_WIDTH-1:0] in_notional,

   output logic                      out_valid,
   input  logic                      out_ready,
   output order_side_e               out_side,
   output order_type_e               out_type,
   output logic [QTY_WIDTH-1:0]      out_qty,
   output logic [NOTIONAL_WIDTH-1:0] out_notional,

   output logic                      rej_valid,
   output risk_reject_e              rej_reason,

   output logic [TOKEN_WIDTH-1:0]    tokens_available,
   output logic [63:0]               total_passed,
   output logic [63:0]               total_rejected
);

   // INIT exists only to load the bucket from cfg_max_tokens once after
   // reset, so the first orders see a full bucket rather than an empty one.
   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e                    state;
   state_e                    state_next;

   logic [TOKEN_WIDTH-1:0]    tokens;
   logic [PERIOD_WIDTH-1:0]   period_cnt;
   logic [PERIOD_WIDTH-1:0]   period_last;
   logic                      tick;

   logic                      accept;
   logic                      bypass;
   logic                      have_token;
   logic                      do_pass;
   logic                      do_consume;
   logic                      do_reject;

   logic [TOKEN_WIDTH:0]      token_sum;
   logic [TOKEN_WIDTH-1:0]    tokens_next;

   assign tokens_available = tokens;

   // State register for the INIT/RUN sequencer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_INIT;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and upstream ready. INIT lasts exactly one cycle with the
   // input closed; in RUN the skid-less output register accepts a new order
   // whenever it is empty or being drained in the same cycle.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      case (state)
         ST_INIT: begin
            state_next = ST_RUN;
         end
         ST_RUN: begin
            in_ready = !out_valid || out_ready;
         end
         default: begin
            state_next = ST_INIT;
         end
      endcase
   end

   // Pass/reject decision, taken from the token count as it stands before
   // this cycle's update, so a refill landing in the same cycle never rescues
   // an order that arrives with the bucket empty.
   always_comb begin
      accept     = in_valid && in_ready;
      bypass     = (in_type == ORDER_CANCEL) || !cfg_enabled;
      have_token = (tokens != '0);
      do_pass    = accept && (bypass || have_token);
      do_consume = accept && !bypass && have_token;
      do_reject  = accept && !bypass && !have_token;
   end

   // Refill tick generation. A period of 0 is treated as 1. The >= compare
   // (rather than ==) lets the counter recover immediately if the period is
   // shortened below the current count instead of running all the way round.
   always_comb begin
      period_last = '0;
      if (cfg_refill_period != '0) begin
         period_last = cfg_refill_period - PERIOD_WIDTH'(1);
      end
      tick = (state == ST_RUN) && (period_cnt >= period_last);
   end

   // Bucket arithmetic is one bit wider than the bucket so that a full bucket
   // plus a full refill cannot wrap before the clamp to cfg_max_tokens.
   // Subtracting the consume cannot underflow: it is only set when tokens>0.
   always_comb begin
      token_sum = {1'b0, tokens}
                - {{TOKEN_WIDTH{1'b0}}, do_consume}
                + (tick ? {1'b0, cfg_refill_tokens} : '0);
      if (token_sum > {1'b0, cfg_max_tokens}) begin
         tokens_next = cfg_max_tokens;
      end else begin
         tokens_next = token_sum[TOKEN_WIDTH-1:0];
      end
   end

   // Period counter and bucket level. The counter is held at zero during
   // INIT so the first refill lands a full period after the bucket is loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         period_cnt <= '0;
         tokens     <= '0;
      end else if (state == ST_INIT) begin
         period_cnt <= '0;
         tokens     <= cfg_max_tokens;
      end else begin
         period_cnt <= tick ? '0 : period_cnt + PERIOD_WIDTH'(1);
         tokens     <= tokens_next;
      end
   end

   // Output register. A passing order loads the payload; otherwise the stage
   // empties once downstream takes it. Payload only changes on a load, which
   // can only happen when the stage is empty or draining, so it holds steady
   // while stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_side     <= SIDE_BUY;
         out_type     <= ORDER_NEW;
         out_qty      <= '0;
         out_notional <= '0;
      end else if (do_pass) begin
         out_valid    <= 1'b1;
         out_side     <= in_side;
         out_type     <= in_type;
         out_qty      <= in_qty;
         out_notional <= in_notional;
      end else if (out_ready) begin
         out_valid    <= 1'b0;
      end
   end

   // Reject pulse: high for the single cycle after the rejecting accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rej_valid  <= 1'b0;
         rej_reason <= RISK_OK;
      end else begin
         rej_valid  <= do_reject;
         rej_reason <= do_reject ? RISK_RATE_LIMIT : RISK_OK;
      end
   end

   // Running order counters, free-running and allowed to wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total_passed   <= '0;
         total_rejected <= '0;
      end else begin
         if (do_pass) begin
            total_passed <= total_passed + 64'd1;
         end
         if (do_reject) begin
            total_rejected <= total_rejected + 64'd1;
         end
      end
   end

endmodule : order_rate_limiter

// File: tb/tb_order_rate_limiter.sv
// ----------------------------------------------------------------------------
// tb_order_rate_limiter
//   Directed bench for order_rate_limiter. Inputs change 1 time unit after
//   each rising edge and outputs are sampled at that same point, so every
//   check sees the registers as updated by the edge just taken.
// ----------------------------------------------------------------------------
module tb_order_rate_limiter;
   import risk_pkg::*;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [15:0]   cfg_max_tokens;
   logic [15:0]   cfg_refill_tokens;
   logic [31:0]   cfg_refill_period;
   logic          cfg_enabled;
   logic          in_valid;
   logic          in_ready;
   order_side_e   in_side;
   order_type_e   in_type;
   logic [63:0]   in_qty;
   logic [63:0]   in_notional;
   logic          out_valid;
   logic          out_ready;
   order_side_e   out_side;
   order_type_e   out_type;
   logic [63:0]   out_qty;
   logic [63:0]   out_notional;
   logic          rej_valid;
   risk_reject_e  rej_reason;
   logic [15:0]   tokens_available;
   logic [63:0]   total_passed;
   logic [63:0]   total_rejected;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   order_rate_limiter dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .cfg_max_tokens    (cfg_max_tokens),
      .cfg_refill_tokens (cfg_refill_tokens),
      .cfg_refill_period (cfg_refill_period),
      .cfg_enabled       (cfg_enabled),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_side           (in_side),
      .in_type           (in_type),
      .in_qty            (in_qty),
      .in_notional       (in_notional),
      .out_valid         (out_valid),
      .out_ready         (out_ready),
      .out_side          (out_side),
      .out_type          (out_type),
      .out_qty           (out_qty),
      .out_notional      (out_notional),
      .rej_valid         (rej_valid),
      .rej_reason        (rej_reason),
      .tokens_available  (tokens_available),
      .total_passed      (total_passed),
      .total_rejected    (total_rejected)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of upstream stimulus, then take the edge.
   task automatic applyStimulus(input logic valid, input order_type_e otype,
                                input logic [63:0] qty);
      in_valid    = valid;
      in_type     = otype;
      in_qty      = qty;
      in_notional = qty * 64'd100;
      in_side     = qty[0] ? SIDE_SELL : SIDE_BUY;
      stepClock();
   endtask

   // Reset with the given bucket setup and walk through the INIT cycle; on
   // return the DUT is in its first RUN cycle with the period counter at 0.
   task automatic resetDut(input logic [15:0] maxTok, input logic [15:0] refill,
                           input logic [31:0] period);
      rst_n             = 1'b0;
      in_valid          = 1'b0;
      out_ready         = 1'b1;
      cfg_enabled       = 1'b1;
      cfg_max_tokens    = maxTok;
      cfg_refill_tokens = refill;
      cfg_refill_period = period;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("init_in_ready", 64'(in_ready), 64'd0);
      stepClock();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n             = 1'b0;
      in_valid          = 1'b0;
      in_side           = SIDE_BUY;
      in_type           = ORDER_NEW;
      in_qty            = '0;
      in_notional       = '0;
      out_ready         = 1'b1;
      cfg_enabled       = 1'b1;
      cfg_max_tokens    = 16'd4;
      cfg_refill_tokens = 16'd1;
      cfg_refill_period = 32'd100;
      #2;

      // Values held in reset.
      checkOutput("rst_tokens",     64'(tokens_available), 64'd0);
      checkOutput("rst_out_valid",  64'(out_valid),        64'd0);
      checkOutput("rst_out_qty",    out_qty,               64'd0);
      checkOutput("rst_rej_valid",  64'(rej_valid),        64'd0);
      checkOutput("rst_rej_reason", 64'(rej_reason),       64'(RISK_OK));
      checkOutput("rst_passed",     total_passed,          64'd0);
      checkOutput("rst_rejected",   total_rejected,        64'd0);
      checkOutput("rst_in_ready",   64'(in_ready),         64'd0);

      // Six back-to-back NEW orders against a 4-token bucket.
      $display("[TB] burst of six orders");
      resetDut(16'd4, 16'd1, 32'd100);
      checkOutput("burst_start_tokens", 64'(tokens_available), 64'd4);
      checkOutput("burst_start_ready",  64'(in_ready),         64'd1);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b1, ORDER_NEW, 64'(i));
         if (i <= 4) begin
            checkOutput("burst_out_valid", 64'(out_valid),        64'd1);
            checkOutput("burst_out_qty",   out_qty,               64'(i));
            checkOutput("burst_out_side",  64'(out_side),         64'(i[0]));
            checkOutput("burst_rej_valid", 64'(rej_valid),        64'd0);
            checkOutput("burst_tokens",    64'(tokens_available), 64'(4 - i));
         end else begin
            checkOutput("burst_rej_out_valid", 64'(out_valid),  64'd0);
            checkOutput("burst_rej_valid",     64'(rej_valid),  64'd1);
            checkOutput("burst_rej_reason",    64'(rej_reason), 64'(RISK_RATE_LIMIT));
         end
      end
      checkOutput("burst_notional", out_notional, 64'd0 + 64'd400);
      applyStimulus(1'b0, ORDER_NEW, 64'd0);
      checkOutput("burst_rej_clear",  64'(rej_valid),        64'd0);
      checkOutput("burst_rej_ok",     64'(rej_reason),       64'(RISK_OK));
      checkOutput("burst_end_tokens", 64'(tokens_available), 64'd0);
      checkOutput("burst_passed",     total_passed,          64'd4);
      checkOutput("burst_rejected",   total_rejected,        64'd2);

      // Refill from empty: +2 every 10 cycles, saturating at 4.
      $display("[TB] refill from empty");
      resetDut(16'd0, 16'd2, 32'd10);
      cfg_max_tokens = 16'd4;
      repeat (9) stepClock();
      checkOutput("refill_9",  64'(tokens_available), 64'd0);
      stepClock();
      checkOutput("refill_10", 64'(tokens_available), 64'd2);
      repeat (10) stepClock();
      checkOutput("refill_20", 64'(tokens_available), 64'd4);
      repeat (10) stepClock();
      checkOutput("refill_30", 64'(tokens_available), 64'd4);

      // Backpressure: output stalled with a second order waiting.
      $display("[TB] backpressure");
      resetDut(16'd4, 16'd1, 32'd100);
      out_ready = 1'b0;
      applyStimulus(1'b1, ORDER_NEW, 64'h11);
      checkOutput("bp_first_valid",  64'(out_valid),        64'd1);
      checkOutput("bp_first_tokens", 64'(tokens_available), 64'd3);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, ORDER_NEW, 64'h22);
         checkOutput("bp_in_ready",  64'(in_ready),         64'd0);
         checkOutput("bp_out_valid", 64'(out_valid),        64'd1);
         checkOutput("bp_out_qty",   out_qty,               64'h11);
         checkOutput("bp_tokens",    64'(tokens_available), 64'd3);
      end
      out_ready = 1'b1;
      #1;
      checkOutput("bp_release_ready", 64'(in_ready), 64'd1);
      applyStimulus(1'b1, ORDER_NEW, 64'h22);
      checkOutput("bp_second_qty",    out_qty,               64'h22);
      checkOutput("bp_second_tokens", 64'(tokens_available), 64'd2);
      applyStimulus(1'b1, ORDER_NEW, 64'h33);
      checkOutput("bp_third_qty",     out_qty,               64'h33);
      checkOutput("bp_third_tokens",  64'(tokens_available), 64'd1);
      checkOutput("bp_passed",        total_passed,          64'd3);
      applyStimulus(1'b0, ORDER_NEW, 64'd0);
      checkOutput("bp_drained",       64'(out_valid),        64'd0);

      // Cancel at an empty bucket is forwarded for free.
      $display("[TB] cancel and bypass");
      resetDut(16'd0, 16'd1, 32'd100);
      applyStimulus(1'b1, ORDER_CANCEL, 64'h7);
      checkOutput("cancel_out_valid", 64'(out_valid),        64'd1);
      checkOutput("cancel_out_type",  64'(out_type),         64'(ORDER_CANCEL));
      checkOutput("cancel_rej_valid", 64'(rej_valid),        64'd0);
      checkOutput("cancel_tokens",    64'(tokens_available), 64'd0);

      // Bypass: limiter disabled, no tokens spent.
      resetDut(16'd3, 16'd1, 32'd100);
      cfg_enabled = 1'b0;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, ORDER_NEW, 64'(8 + i));
         checkOutput("bypass_out_valid", 64'(out_valid),        64'd1);
         checkOutput("bypass_out_qty",   out_qty,               64'(8 + i));
         checkOutput("bypass_tokens",    64'(tokens_available), 64'd3);
      end
      applyStimulus(1'b0, ORDER_NEW, 64'd0);
      checkOutput("bypass_passed",   total_passed,   64'd3);
      checkOutput("bypass_rejected", total_rejected, 64'd0);

      // Tick coinciding with an order at an empty bucket: reject, then refill.
      $display("[TB] tick and order in the same cycle");
      resetDut(16'd0, 16'd2, 32'd4);
      cfg_max_tokens = 16'd4;
      repeat (3) stepClock();
      checkOutput("tick_empty_pre", 64'(tokens_available), 64'd0);
      applyStimulus(1'b1, ORDER_NEW, 64'h55);
      checkOutput("tick_empty_rej",    64'(rej_valid),        64'd1);
      checkOutput("tick_empty_out",    64'(out_valid),        64'd0);
      checkOutput("tick_empty_tokens", 64'(tokens_available), 64'd2);

      // Tick coinciding with an order at a full bucket: pass, stays full.
      resetDut(16'd4, 16'd1, 32'd4);
      repeat (3) stepClock();
      checkOutput("tick_full_pre", 64'(tokens_available), 64'd4);
      applyStimulus(1'b1, ORDER_NEW, 64'h66);
      checkOutput("tick_full_out",    64'(out_valid),        64'd1);
      checkOutput("tick_full_qty",    out_qty,               64'h66);
      checkOutput("tick_full_tokens", 64'(tokens_available), 64'd4);

      // Lowering the capacity clamps the level on the next edge.
      cfg_max_tokens = 16'd2;
      applyStimulus(1'b0, ORDER_NEW, 64'd0);
      checkOutput("clamp_tokens", 64'(tokens_available), 64'd2);

      // Reset while an order sits in the output register.
      $display("[TB] reset mid-operation");
      resetDut(16'd4, 16'd1, 32'd100);
      out_ready = 1'b0;
      applyStimulus(1'b1, ORDER_NEW, 64'h77);
      in_valid = 1'b0;
      checkOutput("midrst_pre_valid",  64'(out_valid), 64'd1);
      checkOutput("midrst_pre_passed", total_passed,   64'd1);
      rst_n          = 1'b0;
      cfg_max_tokens = 16'd3;
      out_ready      = 1'b1;
      #1;
      checkOutput("midrst_out_valid", 64'(out_valid),        64'd0);
      checkOutput("midrst_passed",    total_passed,          64'd0);
      checkOutput("midrst_tokens",    64'(tokens_available), 64'd0);
      checkOutput("midrst_in_ready",  64'(in_ready),         64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checkOutput("midrst_init_ready", 64'(in_ready), 64'd0);
      stepClock();
      checkOutput("midrst_run_ready",  64'(in_ready),         64'd1);
      checkOutput("midrst_run_tokens", 64'(tokens_available), 64'd3);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_order_rate_limiter
